// File: rtl/satalnk_rmcont_if.sv
// Word stream between the RX async FIFO, the CONT/ALIGN remover and the link state machine.
// The remover accepts every valid word and produces one registered result per cycle; no backpressure.
interface satalnk_rmcont_if;
    logic        i_valid;
    logic [32:0] i_data;
    logic        o_valid;
    logic [32:0] o_data;
    logic        o_cont_active;
    logic        o_err;
    logic        o_dbg_hold_valid;

    modport slave (
        input  i_valid, i_data,
        output o_valid, o_data, o_cont_active, o_err, o_dbg_hold_valid
    );

    modport master (
        output i_valid, i_data,
        input  o_valid, o_data, o_cont_active, o_err, o_dbg_hold_valid
    );
endinterface

// File: rtl/satalnk_rmcont.sv
// Strips SATA CONT runs and ALIGNs from the RX word stream, expanding continued primitives
// so the link state machine sees them explicitly repeated; flags illegal CONT and unknown primitives.
module satalnk_rmcont #(
    parameter bit OPT_REPEAT     = 1'b1,
    parameter bit OPT_PASS_ALIGN = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    satalnk_rmcont_if.slave   bus
);
    localparam logic [32:0] P_ALIGN   = 33'h1_7B4A4ABC;
    localparam logic [32:0] P_CONT    = 33'h1_9999AA7C;
    localparam logic [32:0] P_DMAT    = 33'h1_3636B57C;
    localparam logic [32:0] P_EOF     = 33'h1_D5D5B57C;
    localparam logic [32:0] P_HOLD    = 33'h1_D5D5AA7C;
    localparam logic [32:0] P_HOLDA   = 33'h1_9595AA7C;
    localparam logic [32:0] P_PMREQ_P = 33'h1_1717B57C;
    localparam logic [32:0] P_PMREQ_S = 33'h1_7575957C;
    localparam logic [32:0] P_R_ERR   = 33'h1_5656B57C;
    localparam logic [32:0] P_R_IP    = 33'h1_5555B57C;
    localparam logic [32:0] P_R_OK    = 33'h1_3535B57C;
    localparam logic [32:0] P_R_RDY   = 33'h1_4A4A957C;
    localparam logic [32:0] P_SOF     = 33'h1_3737B57C;
    localparam logic [32:0] P_SYNC    = 33'h1_B5B5957C;
    localparam logic [32:0] P_WTRM    = 33'h1_5858B57C;
    localparam logic [32:0] P_X_RDY   = 33'h1_5757B57C;

    typedef enum logic {S_PASS = 1'b0, S_CONT = 1'b1} state_t;

    function automatic logic f_repeatable(input logic [32:0] d);
        case (d)
            P_HOLD, P_HOLDA, P_PMREQ_P, P_PMREQ_S, P_R_ERR, P_R_IP,
            P_R_OK, P_R_RDY, P_SYNC, P_WTRM, P_X_RDY: f_repeatable = 1'b1;
            default:                                   f_repeatable = 1'b0;
        endcase
    endfunction

    state_t      r_state;
    logic [32:0] r_hold;
    logic        r_hold_valid;
    logic        r_drop;       // set by an illegal CONT: junk is discarded until the next primitive
    logic        r_valid;
    logic [32:0] r_data;
    logic        r_err;

    logic w_is_align;
    logic w_is_cont;
    logic w_is_prim;
    logic w_known;
    logic w_cont_ok;

    assign w_is_prim  = bus.i_data[32];
    assign w_is_align = (bus.i_data == P_ALIGN);
    assign w_is_cont  = (bus.i_data == P_CONT);
    assign w_known    = f_repeatable(bus.i_data) || (bus.i_data == P_SOF) ||
                        (bus.i_data == P_EOF) || (bus.i_data == P_DMAT);
    assign w_cont_ok  = r_hold_valid && f_repeatable(r_hold);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_PASS;
            r_hold       <= P_SYNC;
            r_hold_valid <= 1'b0;
            r_drop       <= 1'b0;
            r_valid      <= 1'b0;
            r_data       <= P_SYNC;
            r_err        <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (bus.i_valid) begin
                if (w_is_align) begin
                    // ALIGN is transparent to the CONT run and the held primitive
                    if (OPT_PASS_ALIGN) begin
                        r_valid <= 1'b1;
                        r_data  <= bus.i_data;
                    end
                end else if (w_is_cont) begin
                    r_state <= S_CONT;
                    if (w_cont_ok) begin
                        r_drop  <= 1'b0;
                        r_valid <= 1'b1;
                        r_data  <= r_hold;
                    end else begin
                        r_drop <= 1'b1;
                        r_err  <= 1'b1;
                    end
                end else if (!w_is_prim) begin
                    if (r_state == S_CONT) begin
                        if (OPT_REPEAT && r_hold_valid && !r_drop) begin
                            r_valid <= 1'b1;
                            r_data  <= r_hold;
                        end
                    end else begin
                        r_valid <= 1'b1;
                        r_data  <= bus.i_data;
                    end
                end else if (w_known) begin
                    r_state      <= S_PASS;
                    r_hold       <= bus.i_data;
                    r_hold_valid <= 1'b1;
                    r_drop       <= 1'b0;
                    r_valid      <= 1'b1;
                    r_data       <= bus.i_data;
                end else begin
                    r_state      <= S_PASS;
                    r_hold_valid <= 1'b0;
                    r_drop       <= 1'b0;
                    r_err        <= 1'b1;
                    r_valid      <= 1'b1;
                    r_data       <= bus.i_data;
                end
            end
        end
    end

    assign bus.o_valid          = r_valid;
    assign bus.o_data           = r_data;
    assign bus.o_err            = r_err;
    assign bus.o_cont_active    = (r_state == S_CONT);
    assign bus.o_dbg_hold_valid = r_hold_valid;
endmodule

// File: tb/tb_satalnk_rmcont.sv
// Directed bench for satalnk_rmcont: three parameterisations share one input stream,
// each with its own expected queue of {hold_valid, err, cont_active, valid, data}.
module tb_satalnk_rmcont;
    localparam logic [32:0] P_ALIGN = 33'h1_7B4A4ABC;
    localparam logic [32:0] P_CONT  = 33'h1_9999AA7C;
    localparam logic [32:0] P_EOF   = 33'h1_D5D5B57C;
    localparam logic [32:0] P_HOLD  = 33'h1_D5D5AA7C;
    localparam logic [32:0] P_HOLDA = 33'h1_9595AA7C;
    localparam logic [32:0] P_R_OK  = 33'h1_3535B57C;
    localparam logic [32:0] P_SOF   = 33'h1_3737B57C;
    localparam logic [32:0] P_SYNC  = 33'h1_B5B5957C;
    localparam logic [32:0] P_X_RDY = 33'h1_5757B57C;

    logic        clk = 1'b0;
    logic        tb_reset = 1'b1;
    logic        tb_valid = 1'b0;
    logic [32:0] tb_data = '0;
    int          n_assert = 0;
    int          n_fail = 0;

    logic [36:0] exp_q_a[$];
    logic [36:0] exp_q_b[$];
    logic [36:0] exp_q_c[$];

    always #5 clk = ~clk;

    satalnk_rmcont_if if_a ();
    satalnk_rmcont_if if_b ();
    satalnk_rmcont_if if_c ();

    assign if_a.i_valid = tb_valid;
    assign if_a.i_data  = tb_data;
    assign if_b.i_valid = tb_valid;
    assign if_b.i_data  = tb_data;
    assign if_c.i_valid = tb_valid;
    assign if_c.i_data  = tb_data;

    satalnk_rmcont #(.OPT_REPEAT(1'b1), .OPT_PASS_ALIGN(1'b0)) u_a (.i_clk(clk), .i_reset(tb_reset), .bus(if_a));
    satalnk_rmcont #(.OPT_REPEAT(1'b0), .OPT_PASS_ALIGN(1'b0)) u_b (.i_clk(clk), .i_reset(tb_reset), .bus(if_b));
    satalnk_rmcont #(.OPT_REPEAT(1'b1), .OPT_PASS_ALIGN(1'b1)) u_c (.i_clk(clk), .i_reset(tb_reset), .bus(if_c));

    // Data only matters when the word is valid
    function automatic logic [36:0] mk(input logic h, input logic e, input logic c,
                                       input logic v, input logic [32:0] d);
        mk = {h, e, c, v, (v ? d : 33'h0)};
    endfunction

    task automatic check_one(input string tag, input string dut,
                             input logic [36:0] exp, input logic [36:0] obs);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed h/e/c/v=%b data=%h expected h/e/c/v=%b data=%h",
                   tag, dut, obs[36:33], obs[32:0], exp[36:33], exp[32:0]);
        end
    endtask

    task automatic check_all(input string tag);
        check_one(tag, "A", exp_q_a.pop_front(),
                  mk(if_a.o_dbg_hold_valid, if_a.o_err, if_a.o_cont_active, if_a.o_valid, if_a.o_data));
        check_one(tag, "B", exp_q_b.pop_front(),
                  mk(if_b.o_dbg_hold_valid, if_b.o_err, if_b.o_cont_active, if_b.o_valid, if_b.o_data));
        check_one(tag, "C", exp_q_c.pop_front(),
                  mk(if_c.o_dbg_hold_valid, if_c.o_err, if_c.o_cont_active, if_c.o_valid, if_c.o_data));
    endtask

    task automatic step(input string tag, input logic v, input logic [32:0] d,
                        input logic [36:0] ea, input logic [36:0] eb, input logic [36:0] ec);
        exp_q_a.push_back(ea);
        exp_q_b.push_back(eb);
        exp_q_c.push_back(ec);
        tb_valid = v;
        tb_data  = d;
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic step3(input string tag, input logic v, input logic [32:0] d, input logic [36:0] e);
        step(tag, v, d, e, e, e);
    endtask

    // Reset applied for one cycle with the given input still presented
    task automatic do_reset(input string tag, input logic v, input logic [32:0] d);
        exp_q_a.push_back(mk(0, 0, 0, 0, 33'h0));
        exp_q_b.push_back(mk(0, 0, 0, 0, 33'h0));
        exp_q_c.push_back(mk(0, 0, 0, 0, 33'h0));
        tb_reset = 1'b1;
        tb_valid = v;
        tb_data  = d;
        @(negedge clk);
        tb_reset = 1'b0;
        check_all(tag);
        check_one({tag, "_data"}, "A", {4'b0, P_SYNC}, {4'b0, if_a.o_data});
        check_one({tag, "_data"}, "B", {4'b0, P_SYNC}, {4'b0, if_b.o_data});
        check_one({tag, "_data"}, "C", {4'b0, P_SYNC}, {4'b0, if_c.o_data});
    endtask

    initial begin
        logic [32:0] junk;
        @(negedge clk);
        do_reset("por", 1'b0, 33'h0);

        // Repeatable primitive continued across two junk words
        step3("xrdy0", 1, P_X_RDY, mk(1, 0, 0, 1, P_X_RDY));
        step3("xrdy1", 1, P_X_RDY, mk(1, 0, 0, 1, P_X_RDY));
        step3("cont1", 1, P_CONT,  mk(1, 0, 1, 1, P_X_RDY));
        step("junk1a", 1, 33'h0_DEADBEEF, mk(1, 0, 1, 1, P_X_RDY), mk(1, 0, 1, 0, 0), mk(1, 0, 1, 1, P_X_RDY));
        step("junk1b", 1, 33'h0_12345678, mk(1, 0, 1, 1, P_X_RDY), mk(1, 0, 1, 0, 0), mk(1, 0, 1, 1, P_X_RDY));
        step3("rok",   1, P_R_OK,  mk(1, 0, 0, 1, P_R_OK));
        step3("idle1", 0, 33'h0_0000AAAA, mk(1, 0, 0, 0, 0));

        // HOLD run with ALIGNs, a repeated CONT and an idle cycle inside
        step3("hold",  1, P_HOLD, mk(1, 0, 0, 1, P_HOLD));
        step3("cont2", 1, P_CONT, mk(1, 0, 1, 1, P_HOLD));
        junk = 33'($urandom_range(0, 32'h7FFF_FFFF));
        step("junk2a", 1, junk, mk(1, 0, 1, 1, P_HOLD), mk(1, 0, 1, 0, 0), mk(1, 0, 1, 1, P_HOLD));
        step3("cont2b", 1, P_CONT, mk(1, 0, 1, 1, P_HOLD));
        step("align0", 1, P_ALIGN, mk(1, 0, 1, 0, 0), mk(1, 0, 1, 0, 0), mk(1, 0, 1, 1, P_ALIGN));
        step("align1", 1, P_ALIGN, mk(1, 0, 1, 0, 0), mk(1, 0, 1, 0, 0), mk(1, 0, 1, 1, P_ALIGN));
        step3("idle2", 0, 33'h0, mk(1, 0, 1, 0, 0));
        junk = 33'($urandom_range(0, 32'hFFFF_FFFF));
        step("junk2b", 1, junk, mk(1, 0, 1, 1, P_HOLD), mk(1, 0, 1, 0, 0), mk(1, 0, 1, 1, P_HOLD));
        step3("holda", 1, P_HOLDA, mk(1, 0, 0, 1, P_HOLDA));

        // CONT straight after reset is illegal
        do_reset("rst2", 1'b0, 33'h0);
        step3("cont3",  1, P_CONT, mk(0, 1, 1, 0, 0));
        step3("junk3",  1, 33'h0_00000001, mk(0, 0, 1, 0, 0));
        step3("sync3",  1, P_SYNC, mk(1, 0, 0, 1, P_SYNC));

        // CONT after a non-repeatable primitive, then an unknown primitive
        step3("sof",    1, P_SOF,  mk(1, 0, 0, 1, P_SOF));
        step3("cont4",  1, P_CONT, mk(1, 1, 1, 0, 0));
        step3("junk4",  1, 33'h0_00000055, mk(1, 0, 1, 0, 0));
        step3("unk",    1, 33'h1_AAAAAAAA, mk(0, 1, 0, 1, 33'h1_AAAAAAAA));
        step3("data4",  1, 33'h0_CAFEF00D, mk(0, 0, 0, 1, 33'h0_CAFEF00D));
        step3("cont4b", 1, P_CONT, mk(0, 1, 1, 0, 0));
        step3("junk4b", 1, 33'h0_00000077, mk(0, 0, 1, 0, 0));
        step3("eof",    1, P_EOF,  mk(1, 0, 0, 1, P_EOF));

        // Reset while junk is streaming inside a CONT run
        step3("xrdy5",  1, P_X_RDY, mk(1, 0, 0, 1, P_X_RDY));
        step3("cont5",  1, P_CONT,  mk(1, 0, 1, 1, P_X_RDY));
        step("junk5", 1, 33'h0_0BADF00D, mk(1, 0, 1, 1, P_X_RDY), mk(1, 0, 1, 0, 0), mk(1, 0, 1, 1, P_X_RDY));
        do_reset("rst_mid", 1'b1, 33'h0_0BADF00E);
        step3("data5a", 1, 33'h0_11111111, mk(0, 0, 0, 1, 33'h0_11111111));
        step3("data5b", 1, 33'h0_22222222, mk(0, 0, 0, 1, 33'h0_22222222));

        tb_valid = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/satalnk_rmcont.md
Name: satalnk_rmcont

Overview:
- RX-side link stage between the RX async FIFO output and the link state machine.
- Removes SATA CONT continuation sequences and ALIGN primitives from the received 33-bit word stream (bit 32 = primitive flag).
- Downstream therefore sees every continued primitive explicitly repeated, and never sees scrambled junk.
- Flags illegal CONT usage and unrecognised primitives.

Parameters:
- OPT_REPEAT, 1: 1 = each junk word inside a CONT run is replaced by the held primitive; 0 = junk words are dropped (o_valid low).
- OPT_PASS_ALIGN, 0: 1 = ALIGN primitives are forwarded unchanged; 0 = ALIGN primitives are dropped.

Ports:
- i_clk  input  1  clock (PHY RX-to-TX domain, same clock as the link state machine)
- i_reset  input  1  synchronous, active-high reset
- i_valid  input  1  input word valid; no backpressure
- i_data  input  33  input word; [32]=primitive flag, [31:0]=value; primitive constants from sata_primitives.vh
- o_valid  output  1  output word valid; consumer must accept every cycle
- o_data  output  33  cleaned word
- o_cont_active  output  1  high while inside a CONT run
- o_err  output  1  one-cycle pulse on an illegal CONT or an unknown primitive

Behaviour:
- Reset is synchronous on i_reset. Clock is i_clk.
- Reset values: o_valid=0, o_data=P_SYNC, o_cont_active=0, o_err=0, held primitive register empty (hold_valid=0).
- Latency: all outputs registered, 1 cycle from i_valid to o_valid. No backpressure. When i_valid=0, the next-cycle o_valid=0 and all state is held.
- Repeatable set: HOLD, HOLDA, PMREQ_P, PMREQ_S, R_ERR, R_IP, R_OK, R_RDY, SYNC, WTRM, X_RDY.
- Known set: the repeatable set plus ALIGN, CONT, SOF, EOF, DMAT.
- States: PASS and CONT (o_cont_active=1 in CONT). Per valid input word, with priority top to bottom:
  - ALIGN, any state: state and held primitive unchanged. Output ALIGN only if OPT_PASS_ALIGN=1, otherwise o_valid=0. ALIGN never ends a CONT run.
  - CONT with hold_valid=1 and the held primitive repeatable: go to CONT and output the held primitive. A CONT received while already in CONT does the same.
  - CONT with hold_valid=0, or with a non-repeatable held primitive: o_err=1, go to CONT, o_valid=0. Junk words are then dropped until the next primitive, regardless of OPT_REPEAT.
  - Data word (bit32=0) in CONT: if OPT_REPEAT=1 and hold_valid=1, output the held primitive; otherwise o_valid=0.
  - Data word in PASS: output unchanged.
  - Known non-CONT, non-ALIGN primitive: go to PASS, latch it as the held primitive (hold_valid=1), output it.
  - Unknown primitive: o_err=1, go to PASS, hold_valid=0, output it unchanged so the link state machine can treat it as it chooses.
- Comparisons use all 33 bits.
- Reset mid-run: the next cycle is in PASS, hold_valid=0, o_valid=0. A CONT arriving immediately after reset is therefore an illegal CONT (o_err).
- o_err is never asserted together with a forwarded junk word.

Test Plan:
- X_RDY, X_RDY, CONT, 33'h0_DEADBEEF, 33'h0_12345678, R_OK (OPT_REPEAT=1) -> o_data = X_RDY, X_RDY, X_RDY, X_RDY, X_RDY, R_OK; o_cont_active high from the cycle after CONT through the two junk words, low with R_OK; o_err never asserted.
- Same stream with OPT_REPEAT=0 -> X_RDY, X_RDY, X_RDY, then o_valid low for 2 cycles, then R_OK.
- HOLD, CONT, junk, ALIGN, ALIGN, junk, HOLDA -> ALIGNs dropped (o_valid low), CONT run is not ended by ALIGN, all junk replaced by HOLD, then HOLDA; with OPT_PASS_ALIGN=1 the two ALIGNs appear in place.
- Reset, then CONT, 33'h0_00000001, SYNC -> o_err pulse 1 cycle after CONT, no valid output for CONT or the junk word, then SYNC passed with o_cont_active=0.
- SOF, CONT, 33'h0_00000055 -> o_err on CONT (SOF not repeatable), junk dropped. Then an unknown primitive 33'h1_AAAAAAAA -> forwarded with an o_err pulse and hold_valid cleared.
- i_reset asserted mid-CONT run during continuous junk -> o_valid=0, o_cont_active=0, o_data=P_SYNC the following cycle; subsequent data words pass through unchanged.
